hbm_axis_adapter_fc: RTL and testbench

Flow-controlled successor to the plain HBM stream adapter. Sits between the traffic generator AXI-Stream ports and the HBM controller core. Adds a registered command skid buffer on the write/command path and a read-data FIFO on the return path. Read commands are credit-gated so the non-stallable controller read return can never overflow the FIFO, and m_axis_rd_tready backpressure is honoured. Generates tlast per read burst.

---
 rtl/hbm_axis_adapter_fc.sv | 211 +++++++++++++++++++++
 tb/tb_hbm_axis_adapter_fc.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hbm_axis_adapter_fc.sv
// Flow-controlled AXIS <-> HBM core adapter: 2-entry command skid buffer, credit-gated reads,
// read-return FIFO with per-burst tlast. Define ADAPTER_STATS_EN to add statistics counters.
module hbm_axis_adapter_fc #(
  parameter int unsigned C_S_AXIS_WR_TUSER_WIDTH = 25,
  parameter int unsigned C_S_AXIS_WR_TDATA_WIDTH = 1024,
  parameter int unsigned C_M_AXIS_RD_TDATA_WIDTH = 1024,
  parameter int unsigned CMD_RD_BIT              = 24,
  parameter int unsigned RD_FIFO_DEPTH           = 16,
  parameter int unsigned RD_BURST_LEN            = 8
) (
  input  logic                                   ap_clk,
  input  logic                                   ap_rst,
  input  logic                                   s_axis_wr_tvalid,
  output logic                                   s_axis_wr_tready,
  input  logic [C_S_AXIS_WR_TDATA_WIDTH-1:0]     s_axis_wr_tdata,
  input  logic [C_S_AXIS_WR_TUSER_WIDTH-1:0]     s_axis_wr_tuser,
  input  logic [C_S_AXIS_WR_TDATA_WIDTH/8-1:0]   s_axis_wr_tkeep,
  input  logic                                   s_axis_wr_tlast,
  input  logic                                   i_controller_ready,
  output logic                                   o_command_valid,
  output logic [C_S_AXIS_WR_TUSER_WIDTH-1:0]     o_command,
  output logic [C_S_AXIS_WR_TDATA_WIDTH-1:0]     o_write_data,
  input  logic                                   i_read_data_valid,
  input  logic [C_M_AXIS_RD_TDATA_WIDTH-1:0]     i_read_data,
  output logic                                   m_axis_rd_tvalid,
  input  logic                                   m_axis_rd_tready,
  output logic [C_M_AXIS_RD_TDATA_WIDTH-1:0]     m_axis_rd_tdata,
  output logic [C_M_AXIS_RD_TDATA_WIDTH/8-1:0]   m_axis_rd_tkeep,
  output logic                                   m_axis_rd_tlast,
  output logic                                   o_rd_overflow
`ifdef ADAPTER_STATS_EN
  ,
  output logic [31:0]                            o_stat_wr_cmds,
  output logic [31:0]                            o_stat_rd_cmds,
  output logic [31:0]                            o_stat_credit_stalls
`endif
);

  localparam int unsigned CW  = C_S_AXIS_WR_TUSER_WIDTH;
  localparam int unsigned WW  = C_S_AXIS_WR_TDATA_WIDTH;
  localparam int unsigned RW  = C_M_AXIS_RD_TDATA_WIDTH;
  localparam int unsigned AW  = $clog2(RD_FIFO_DEPTH);
  localparam int unsigned FCW = AW + 1;
  localparam int unsigned CRW = $clog2(RD_FIFO_DEPTH + 1);
  localparam int unsigned BW  = (RD_BURST_LEN > 1) ? $clog2(RD_BURST_LEN) : 1;

  // command skid buffer: slot 0 is the head presented to the core
  logic [CW-1:0]  cmd0_q, cmd0_d, cmd1_q, cmd1_d;
  logic [WW-1:0]  wd0_q, wd0_d, wd1_q, wd1_d;
  logic [1:0]     cnt_q, cnt_d, cnt_pop;
  logic           tready_q, tready_d;
  logic           cmd_valid_q, cmd_valid_d;
  logic [CRW-1:0] credit_q, credit_d;

  // read return FIFO
  logic [RW-1:0]  mem_q [RD_FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           rvalid_q, rvalid_d;
  logic           rlast_q, rlast_d;
  logic [BW-1:0]  beat_q, beat_d;
  logic           ovf_q, ovf_d;

  logic cmd_xfer, cmd_acc, head_rd, rd_issue, rd_pop, fifo_full, fifo_push;

  logic unused_ok;
  assign unused_ok = ^{s_axis_wr_tkeep, s_axis_wr_tlast};

  always_comb begin
    cmd0_d    = cmd0_q;
    cmd1_d    = cmd1_q;
    wd0_d     = wd0_q;
    wd1_d     = wd1_q;
    credit_d  = credit_q;
    beat_d    = beat_q;
    cmd_xfer  = cmd_valid_q && i_controller_ready;
    cmd_acc   = s_axis_wr_tvalid && tready_q;
    head_rd   = cmd0_q[CMD_RD_BIT];
    rd_issue  = cmd_xfer && head_rd;
    rd_pop    = rvalid_q && m_axis_rd_tready;
    fifo_full = (fcnt_q == FCW'(RD_FIFO_DEPTH));
    fifo_push = i_read_data_valid && (!fifo_full || rd_pop);

    // pop shifts slot 1 forward, then an accepted beat lands in the first free slot
    cnt_pop = cnt_q - 2'(cmd_xfer);
    if (cmd_xfer) begin
      cmd0_d = cmd1_q;
      wd0_d  = wd1_q;
    end
    if (cmd_acc) begin
      if (cnt_pop == 2'd0) begin
        cmd0_d = s_axis_wr_tuser;
        wd0_d  = s_axis_wr_tdata;
      end else begin
        cmd1_d = s_axis_wr_tuser;
        wd1_d  = s_axis_wr_tdata;
      end
    end
    cnt_d    = cnt_pop + 2'(cmd_acc);
    tready_d = (cnt_d < 2'd2);

    // outstanding-read credits, clamped so stray returns cannot wrap the count
    if (rd_issue && !rd_pop && (credit_q < CRW'(RD_FIFO_DEPTH))) begin
      credit_d = credit_q + CRW'(1);
    end else if (!rd_issue && rd_pop && (credit_q != '0)) begin
      credit_d = credit_q - CRW'(1);
    end
    cmd_valid_d = (cnt_d != 2'd0) &&
                  (!cmd0_d[CMD_RD_BIT] || (credit_d < CRW'(RD_FIFO_DEPTH)));

    wr_ptr_d = wr_ptr_q + AW'(fifo_push);
    rd_ptr_d = rd_ptr_q + AW'(rd_pop);
    fcnt_d   = fcnt_q + FCW'(fifo_push) - FCW'(rd_pop);
    ovf_d    = ovf_q || (i_read_data_valid && !fifo_push);
    if (rd_pop) begin
      beat_d = (beat_q == BW'(RD_BURST_LEN - 1)) ? '0 : beat_q + BW'(1);
    end
    rvalid_d = (fcnt_d != '0);
    rlast_d  = rvalid_d && (beat_d == BW'(RD_BURST_LEN - 1));
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      cmd0_q      <= '0;
      cmd1_q      <= '0;
      wd0_q       <= '0;
      wd1_q       <= '0;
      cnt_q       <= '0;
      tready_q    <= 1'b0;
      cmd_valid_q <= 1'b0;
      credit_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      fcnt_q      <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      beat_q      <= '0;
      ovf_q       <= 1'b0;
    end else begin
      cmd0_q      <= cmd0_d;
      cmd1_q      <= cmd1_d;
      wd0_q       <= wd0_d;
      wd1_q       <= wd1_d;
      cnt_q       <= cnt_d;
      tready_q    <= tready_d;
      cmd_valid_q <= cmd_valid_d;
      credit_q    <= credit_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      fcnt_q      <= fcnt_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      beat_q      <= beat_d;
      ovf_q       <= ovf_d;
    end
  end

  // storage has no reset; validity is tracked by the occupancy count
  always_ff @(posedge ap_clk) begin
    if (fifo_push) begin
      mem_q[wr_ptr_q] <= i_read_data;
    end
  end

  assign s_axis_wr_tready = tready_q;
  assign o_command_valid  = cmd_valid_q;
  assign o_command        = cmd0_q;
  assign o_write_data     = wd0_q;
  assign m_axis_rd_tvalid = rvalid_q;
  assign m_axis_rd_tdata  = mem_q[rd_ptr_q];
  assign m_axis_rd_tkeep  = '1;
  assign m_axis_rd_tlast  = rlast_q;
  assign o_rd_overflow    = ovf_q;

`ifdef ADAPTER_STATS_EN
  logic [31:0] st_wr_q, st_wr_d, st_rd_q, st_rd_d, st_stall_q, st_stall_d;

  always_comb begin
    st_wr_d    = st_wr_q;
    st_rd_d    = st_rd_q;
    st_stall_d = st_stall_q;
    if (cmd_xfer && !head_rd) begin
      st_wr_d = st_wr_q + 32'd1;
    end
    if (rd_issue) begin
      st_rd_d = st_rd_q + 32'd1;
    end
    // head read held back only because every credit is in use
    if ((cnt_q != 2'd0) && head_rd && (credit_q >= CRW'(RD_FIFO_DEPTH))) begin
      st_stall_d = st_stall_q + 32'd1;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      st_wr_q    <= '0;
      st_rd_q    <= '0;
      st_stall_q <= '0;
    end else begin
      st_wr_q    <= st_wr_d;
      st_rd_q    <= st_rd_d;
      st_stall_q <= st_stall_d;
    end
  end

  assign o_stat_wr_cmds       = st_wr_q;
  assign o_stat_rd_cmds       = st_rd_q;
  assign o_stat_credit_stalls = st_stall_q;
`endif

endmodule

// File: tb/tb_hbm_axis_adapter_fc.sv
// Randomized self-checking bench for hbm_axis_adapter_fc against a queue-based reference model.
module tb_hbm_axis_adapter_fc;
  localparam int TW = 25, DW = 1024, KW = DW / 8, DEPTH = 16, BLEN = 8, RDB = 24;

  typedef struct {
    logic [TW-1:0] cmd;
    logic [DW-1:0] data;
  } beat_t;

  logic          ap_clk = 1'b0;
  logic          ap_rst = 1'b1;
  logic          s_tvalid = 1'b0;
  logic          s_tready;
  logic [DW-1:0] s_tdata = '0;
  logic [TW-1:0] s_tuser = '0;
  logic [KW-1:0] s_tkeep = '1;
  logic          s_tlast = 1'b0;
  logic          ctrl_rdy = 1'b0;
  logic          cvalid;
  logic [TW-1:0] cmd;
  logic [DW-1:0] wdata;
  logic          rdv = 1'b0;
  logic [DW-1:0] rdata = '0;
  logic          rvalid;
  logic          rd_rdy = 1'b0;
  logic [DW-1:0] rtdata;
  logic [KW-1:0] rtkeep;
  logic          rtlast;
  logic          ovf;

  hbm_axis_adapter_fc dut (
    .ap_clk             (ap_clk),
    .ap_rst             (ap_rst),
    .s_axis_wr_tvalid   (s_tvalid),
    .s_axis_wr_tready   (s_tready),
    .s_axis_wr_tdata    (s_tdata),
    .s_axis_wr_tuser    (s_tuser),
    .s_axis_wr_tkeep    (s_tkeep),
    .s_axis_wr_tlast    (s_tlast),
    .i_controller_ready (ctrl_rdy),
    .o_command_valid    (cvalid),
    .o_command          (cmd),
    .o_write_data       (wdata),
    .i_read_data_valid  (rdv),
    .i_read_data        (rdata),
    .m_axis_rd_tvalid   (rvalid),
    .m_axis_rd_tready   (rd_rdy),
    .m_axis_rd_tdata    (rtdata),
    .m_axis_rd_tkeep    (rtkeep),
    .m_axis_rd_tlast    (rtlast),
    .o_rd_overflow      (ovf)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (low 192 bits shown)", nm, act[191:0], exp[191:0]);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int i);
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = 32'(i * 64 + k) ^ 32'hA5A50000;
    return v;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom();
    return v;
  endfunction

  // ---------------- reference model ----------------
  beat_t         mq[$];
  logic [DW-1:0] fq[$];
  int            m_credit = 0;
  int            m_beats  = 0;
  bit            m_ovf    = 1'b0;
  bit            m_wr_rdy = 1'b0;
  bit            mb_xfer, mb_rd, mb_acc, mb_pop;

  function automatic bit model_cvalid();
    if (mq.size() == 0) return 1'b0;
    return !mq[0].cmd[RDB] || (m_credit < DEPTH);
  endfunction

  always @(posedge ap_clk) begin
    if (ap_rst) begin
      mq.delete();
      fq.delete();
      m_credit = 0;
      m_beats  = 0;
      m_ovf    = 1'b0;
      m_wr_rdy = 1'b0;
    end else begin
      mb_xfer = model_cvalid() && ctrl_rdy;
      mb_rd   = 1'b0;
      mb_acc  = s_tvalid && m_wr_rdy;
      mb_pop  = (fq.size() > 0) && rd_rdy;
      if (mb_xfer) begin
        mb_rd = mq[0].cmd[RDB];
        void'(mq.pop_front());
      end
      if (mb_acc) mq.push_back('{s_tuser, s_tdata});
      m_credit = m_credit + int'(mb_rd) - int'(mb_pop);
      if (m_credit < 0) m_credit = 0;
      if (m_credit > DEPTH) m_credit = DEPTH;
      if (mb_pop) begin
        void'(fq.pop_front());
        m_beats++;
      end
      if (rdv) begin
        if (fq.size() < DEPTH) fq.push_back(rdata);
        else m_ovf = 1'b1;
      end
      m_wr_rdy = (mq.size() < 2);
    end
    #1;
    if (!ap_rst) begin
      check("wr_tready", DW'(s_tready), DW'(m_wr_rdy));
      check("cmd_valid", DW'(cvalid), DW'(model_cvalid()));
      if (mq.size() > 0) begin
        check("command", DW'(cmd), DW'(mq[0].cmd));
        check("write_data", wdata, mq[0].data);
      end
      check("rd_tvalid", DW'(rvalid), DW'(fq.size() > 0));
      if (fq.size() > 0) check("rd_tdata", rtdata, fq[0]);
      check("rd_tlast", DW'(rtlast), DW'((fq.size() > 0) && (m_beats % BLEN == BLEN - 1)));
      check("rd_overflow", DW'(ovf), DW'(m_ovf));
      check("rd_tkeep", DW'(rtkeep), DW'({KW{1'b1}}));
    end
  end

  // ---------------- stimulus driver / core emulator ----------------
  beat_t         tx_q[$];
  int            ret_q[$];
  logic [TW-1:0] wr_log[$];
  logic [DW-1:0] pop_data[$];
  bit            pop_last[$];
  int  cyc = 0, last_ret = 0, rd_issued = 0;
  int  src_rate = 100, ctrl_mode = 0, rrdy_mode = 0, force_rd = 0, force_idx = 0;
  bit  ctrl_val = 1'b1, rrdy_val = 1'b0, core_en = 1'b0;
  bit  p_wr_acc = 1'b0, p_xfer = 1'b0, p_pop = 1'b0, p_plast = 1'b0;
  logic [TW-1:0] p_cmd = '0;
  logic [DW-1:0] p_pdata = '0;
  beat_t         drv_b;
  int            drv_t;

  always @(negedge ap_clk) begin
    if (ap_rst) begin
      s_tvalid = 1'b0;
      rdv      = 1'b0;
      ctrl_rdy = 1'b0;
      rd_rdy   = 1'b0;
      ret_q.delete();
      tx_q.delete();
      force_rd = 0;
      last_ret = 0;
      p_wr_acc = 1'b0;
      p_xfer   = 1'b0;
      p_pop    = 1'b0;
    end else begin
      cyc++;
      if (p_wr_acc) s_tvalid = 1'b0;
      if (p_xfer) begin
        if (p_cmd[RDB]) begin
          rd_issued++;
          if (core_en) begin
            drv_t = cyc + int'($urandom_range(0, 4));
            if (drv_t <= last_ret) drv_t = last_ret + 1;
            last_ret = drv_t;
            ret_q.push_back(drv_t);
          end
        end else begin
          wr_log.push_back(p_cmd);
        end
      end
      if (p_pop) begin
        pop_data.push_back(p_pdata);
        pop_last.push_back(p_plast);
      end
      if (!s_tvalid && (tx_q.size() > 0) && ($urandom_range(0, 99) < src_rate)) begin
        drv_b    = tx_q.pop_front();
        s_tvalid = 1'b1;
        s_tuser  = drv_b.cmd;
        s_tdata  = drv_b.data;
      end
      case (ctrl_mode)
        0:       ctrl_rdy = ctrl_val;
        1:       ctrl_rdy = !ctrl_rdy;
        default: ctrl_rdy = ($urandom_range(0, 1) == 1);
      endcase
      rd_rdy = (rrdy_mode == 0) ? rrdy_val : ($urandom_range(0, 3) != 0);
      rdv = 1'b0;
      if (force_rd > 0) begin
        rdv   = 1'b1;
        rdata = mk(force_idx);
        force_idx++;
        force_rd--;
      end else if ((ret_q.size() > 0) && (ret_q[0] <= cyc)) begin
        rdv   = 1'b1;
        rdata = rnd_word();
        void'(ret_q.pop_front());
      end
      p_wr_acc = s_tvalid && s_tready;
      p_xfer   = cvalid && ctrl_rdy;
      p_cmd    = cmd;
      p_pop    = rvalid && rd_rdy;
      p_pdata  = rtdata;
      p_plast  = rtlast;
    end
  end

  // ---------------- directed sequence ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge ap_clk);
    #3;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tready"}, DW'(s_tready), '0);
    check({tag, "_cvalid"}, DW'(cvalid), '0);
    check({tag, "_command"}, DW'(cmd), '0);
    check({tag, "_wdata"}, wdata, '0);
    check({tag, "_rvalid"}, DW'(rvalid), '0);
    check({tag, "_rlast"}, DW'(rtlast), '0);
    check({tag, "_ovf"}, DW'(ovf), '0);
    check({tag, "_tkeep"}, DW'(rtkeep), DW'({KW{1'b1}}));
  endtask

  task automatic do_reset(input string tag);
    @(posedge ap_clk);
    #2 ap_rst = 1'b1;
    #1 check_reset_outputs(tag);
    repeat (2) @(posedge ap_clk);
    #2 ap_rst = 1'b0;
  endtask

  task automatic push_cmds(input int n, input int rd_pct);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.cmd = TW'($urandom());
      b.cmd[RDB] = ($urandom_range(0, 99) < rd_pct);
      b.data = rnd_word();
      tx_q.push_back(b);
    end
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && ((tx_q.size() > 0) || s_tvalid); i++) @(posedge ap_clk);
    check({tag, "_drain_timeout"}, DW'(tx_q.size() + int'(s_tvalid)), '0);
    wait_cycles(80);
  endtask

  initial begin
    logic [TW-1:0] exp_w[4];
    logic [TW-1:0] last_rd;
    beat_t b;

    repeat (3) @(posedge ap_clk);
    #3 check_reset_outputs("por");
    @(posedge ap_clk);
    #2 ap_rst = 1'b0;

    // four writes, controller always ready
    ctrl_mode = 0; ctrl_val = 1'b1; rrdy_mode = 0; rrdy_val = 1'b0; core_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      b.cmd  = {1'b0, 24'(i * 3 + 1)};
      b.data = mk(1000 + i);
      exp_w[i] = b.cmd;
      tx_q.push_back(b);
    end
    wait_cycles(20);
    check("t1_wr_count", DW'(wr_log.size()), DW'(4));
    for (int i = 0; i < 4; i++)
      if (i < wr_log.size()) check("t1_wr_order", DW'(wr_log[i]), DW'(exp_w[i]));
    check("t1_rd_issued", DW'(rd_issued), '0);

    // 17 reads with no returns: exactly 16 issue
    last_rd = '0;
    for (int i = 0; i < 17; i++) begin
      b.cmd  = {1'b1, 24'(100 + i)};
      b.data = mk(2000 + i);
      last_rd = b.cmd;
      tx_q.push_back(b);
    end
    wait_cycles(40);
    check("t2_rd_issued", DW'(rd_issued), DW'(16));
    check("t2_cvalid_held", DW'(cvalid), '0);
    check("t2_head_cmd", DW'(cmd), DW'(last_rd));
    check("t2_tready", DW'(s_tready), DW'(1));

    // fill FIFO with consumer stalled, then overflow it
    force_idx = 0; force_rd = 16;
    wait_cycles(25);
    check("t3_full_ovf", DW'(ovf), '0);
    check("t3_full_valid", DW'(rvalid), DW'(1));
    force_rd = 1;
    wait_cycles(5);
    check("t3_ovf_set", DW'(ovf), DW'(1));
    pop_data.delete(); pop_last.delete();
    rrdy_val = 1'b1;
    wait_cycles(30);
    check("t3_pop_count", DW'(pop_data.size()), DW'(16));
    for (int i = 0; i < 16; i++) begin
      if (i < pop_data.size()) begin
        check("t3_pop_data", pop_data[i], mk(i));
        check("t3_pop_tlast", DW'(pop_last[i]), DW'((i % BLEN) == BLEN - 1));
      end
    end
    check("t3_ovf_sticky", DW'(ovf), DW'(1));
    check("t3_rd_issued", DW'(rd_issued), DW'(17));

    // toggling controller ready with continuous mixed traffic
    do_reset("rst1");
    rd_issued = 0;
    ctrl_mode = 1; core_en = 1'b1; rrdy_mode = 0; rrdy_val = 1'b1; src_rate = 100;
    push_cmds(150, 50);
    wait_drain("toggle", 3000);

    // fully randomized phase
    ctrl_mode = 2; rrdy_mode = 1; src_rate = 60;
    push_cmds(400, 60);
    wait_drain("random", 8000);
    check("random_no_ovf", DW'(ovf), '0);

    // reset in the middle of traffic, then a clean burst
    push_cmds(100, 70);
    wait_cycles(40);
    do_reset("rst2");
    pop_data.delete(); pop_last.delete(); wr_log.delete(); rd_issued = 0;
    ctrl_mode = 0; ctrl_val = 1'b1; rrdy_mode = 0; rrdy_val = 1'b1; core_en = 1'b1; src_rate = 100;
    for (int i = 0; i < 8; i++) begin
      b.cmd  = {1'b1, 24'(500 + i)};
      b.data = mk(3000 + i);
      tx_q.push_back(b);
    end
    wait_cycles(50);
    check("t6_rd_issued", DW'(rd_issued), DW'(8));
    check("t6_pop_count", DW'(pop_data.size()), DW'(8));
    for (int i = 0; i < 8; i++)
      if (i < pop_last.size()) check("t6_pop_tlast", DW'(pop_last[i]), DW'(i == 7));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
